// File: rtl/matrix_ops_gen.sv
// DIM x DIM bit matrix: toggle/read a cell, or stream a row/column serially on Z. Optional pop counter via MATRIXOPS_POPCOUNT_EN.
// Latency: READ 1 cycle, scans DIM back-to-back bits from the accept edge; enter is ignored (not queued) while busy.
module matrix_ops_gen #(
   parameter int DIM = 4,
   localparam int AW = $clog2(DIM)
`ifdef MATRIXOPS_POPCOUNT_EN
   ,
   localparam int PW = $clog2(DIM*DIM+1)
`endif
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enter,
   input  logic [1:0]    op,
   input  logic [AW-1:0] X,
   input  logic [AW-1:0] Y,
   output logic          Z,
   output logic          z_valid,
   output logic          busy
`ifdef MATRIXOPS_POPCOUNT_EN
   ,
   output logic [PW-1:0] pop
`endif
);

   localparam logic [1:0] OP_TOGGLE  = 2'd0;
   localparam logic [1:0] OP_READ    = 2'd1;
   localparam logic [1:0] OP_ROWSCAN = 2'd2;
   localparam logic [1:0] OP_COLSCAN = 2'd3;

   localparam logic [AW:0]   DIM_W = (AW+1)'(DIM);
   localparam logic [AW-1:0] LAST  = AW'(DIM-1);

   typedef enum logic {IDLE, SCAN} state_t;

   logic [DIM-1:0][DIM-1:0] m;       // m[row][col]
   state_t                  state;
   logic [AW-1:0]           sel;
   logic [AW-1:0]           idx;
   logic                    scan_col;
   logic                    x_ok;
   logic                    y_ok;
   logic                    accept;
   logic                    scan_bit;

   // Range checks only matter when DIM is not a power of two.
   always_comb begin
      x_ok   = ({1'b0, X} < DIM_W);
      y_ok   = ({1'b0, Y} < DIM_W);
      accept = 1'b0;
      case (op)
         OP_ROWSCAN: accept = x_ok;
         OP_COLSCAN: accept = y_ok;
         default:    accept = x_ok && y_ok;
      endcase
      accept   = accept && enter && (state == IDLE);
      scan_bit = scan_col ? m[idx][sel] : m[sel][idx];
   end

   assign busy = (state == SCAN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m        <= '0;
         state    <= IDLE;
         Z        <= 1'b0;
         z_valid  <= 1'b0;
         sel      <= '0;
         idx      <= '0;
         scan_col <= 1'b0;
`ifdef MATRIXOPS_POPCOUNT_EN
         pop      <= '0;
`endif
      end else begin
         Z       <= 1'b0;
         z_valid <= 1'b0;
         if (state == SCAN) begin
            // Matrix is frozen during a scan, so the stream is a consistent snapshot.
            Z       <= scan_bit;
            z_valid <= 1'b1;
            idx     <= idx + 1'b1;
            if (idx == LAST)
               state <= IDLE;
         end else if (accept) begin
            case (op)
               OP_TOGGLE: begin
                  m[X][Y] <= ~m[X][Y];
`ifdef MATRIXOPS_POPCOUNT_EN
                  if (m[X][Y])
                     pop <= pop - 1'b1;
                  else
                     pop <= pop + 1'b1;
`endif
               end
               OP_READ: begin
                  Z       <= m[X][Y];
                  z_valid <= 1'b1;
               end
               OP_ROWSCAN: begin
                  sel      <= X;
                  scan_col <= 1'b0;
                  idx      <= AW'(1);
                  state    <= SCAN;
                  Z        <= m[X][0];
                  z_valid  <= 1'b1;
               end
               default: begin
                  sel      <= Y;
                  scan_col <= 1'b1;
                  idx      <= AW'(1);
                  state    <= SCAN;
                  Z        <= m[0][Y];
                  z_valid  <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_matrix_ops_gen.sv
// Directed bench for matrix_ops_gen: a DIM=4 instance for the main ops and a DIM=3 instance for out-of-range addresses.
module tb_matrix_ops_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       enter4 = 1'b0;
   logic [1:0] op4 = 2'd0;
   logic [1:0] x4 = 2'd0;
   logic [1:0] y4 = 2'd0;
   logic       z4, zv4, busy4;

   logic       enter3 = 1'b0;
   logic [1:0] op3 = 2'd0;
   logic [1:0] x3 = 2'd0;
   logic [1:0] y3 = 2'd0;
   logic       z3, zv3, busy3;

`ifdef MATRIXOPS_POPCOUNT_EN
   logic [4:0] pop4;
   logic [3:0] pop3;
`endif

   int checks = 0;
   int errors = 0;

   matrix_ops_gen #(.DIM(4)) u4 (
      .clk(clk), .rst(rst), .enter(enter4), .op(op4), .X(x4), .Y(y4),
      .Z(z4), .z_valid(zv4), .busy(busy4)
`ifdef MATRIXOPS_POPCOUNT_EN
      , .pop(pop4)
`endif
   );

   matrix_ops_gen #(.DIM(3)) u3 (
      .clk(clk), .rst(rst), .enter(enter3), .op(op3), .X(x3), .Y(y3),
      .Z(z3), .z_valid(zv3), .busy(busy3)
`ifdef MATRIXOPS_POPCOUNT_EN
      , .pop(pop3)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op_4(input logic [1:0] o, input logic [1:0] x, input logic [1:0] y);
      enter4 = 1'b1; op4 = o; x4 = x; y4 = y;
      tick();
      enter4 = 1'b0;
   endtask

   task automatic op_3(input logic [1:0] o, input logic [1:0] x, input logic [1:0] y);
      enter3 = 1'b1; op3 = o; x3 = x; y3 = y;
      tick();
      enter3 = 1'b0;
   endtask

   task automatic read_4(input string tag, input logic [1:0] x, input logic [1:0] y, input logic exp);
      op_4(2'd1, x, y);
      check({tag, "_vld"}, zv4, 1);
      check(tag, z4, exp);
   endtask

   // exp[i] is the i-th bit of the stream.
   task automatic scan_4(input string tag, input logic [1:0] o, input logic [1:0] a, input logic [3:0] exp);
      int nbusy = 0;
      op_4(o, a, a);
      for (int i = 0; i < 4; i++) begin
         check({tag, "_vld"}, zv4, 1);
         check({tag, "_bit"}, z4, exp[i]);
         nbusy += int'(busy4);
         if (i < 3) tick();
      end
      check({tag, "_busy_cycles"}, nbusy, 3);
      tick();
      check({tag, "_vld_end"}, zv4, 0);
      check({tag, "_z_end"}, z4, 0);
   endtask

   initial begin
      logic [7:0] exp8;
      logic [2:0] exp3;
      int nbusy;

      #2 rst = 1'b0;
      #1;
      check("rst_z", z4, 0);
      check("rst_vld", zv4, 0);
      check("rst_busy", busy4, 0);
      tick();
      @(negedge clk) rst = 1'b1;
      tick();
`ifdef MATRIXOPS_POPCOUNT_EN
      check("rst_pop", pop4, 0);
`endif

      op_4(2'd0, 2'd0, 2'd0);
      check("toggle_no_vld", zv4, 0);
      op_4(2'd0, 2'd2, 2'd0);
      op_4(2'd0, 2'd1, 2'd1);
      op_4(2'd0, 2'd1, 2'd3);
      op_4(2'd0, 2'd3, 2'd3);
      op_4(2'd0, 2'd0, 2'd2);
`ifdef MATRIXOPS_POPCOUNT_EN
      check("pop_six", pop4, 6);
`endif

      read_4("read11", 2'd1, 2'd1, 1'b1);
      tick();
      check("read11_pulse_end", zv4, 0);
      read_4("read21", 2'd2, 2'd1, 1'b0);
      tick();

      scan_4("row1", 2'd2, 2'd1, 4'b1010);
      scan_4("col0", 2'd3, 2'd0, 4'b0101);

      // ROWSCAN X=1 with TOGGLE(1,2) and READ(0,0) held on enter during the scan.
      enter4 = 1'b1; op4 = 2'd2; x4 = 2'd1; y4 = 2'd0;
      tick();
      check("mid_b0", z4, 0);
      op4 = 2'd0; x4 = 2'd1; y4 = 2'd2;
      tick();
      check("mid_b1", z4, 1);
      op4 = 2'd1; x4 = 2'd0; y4 = 2'd0;
      tick();
      check("mid_b2", z4, 0);
      tick();
      check("mid_b3", z4, 1);
      enter4 = 1'b0;
      tick();
      check("mid_no_extra_vld", zv4, 0);
      read_4("mid_read12", 2'd1, 2'd2, 1'b0);
      tick();

      // ROWSCAN X=0 then COLSCAN Y=3 on the edge after the last bit.
      exp8 = 8'b1010_0101;
      enter4 = 1'b1; op4 = 2'd2; x4 = 2'd0; y4 = 2'd0;
      tick();
      enter4 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("chain_vld", zv4, 1);
         check("chain_bit", z4, exp8[i]);
         if (i == 3) begin
            enter4 = 1'b1; op4 = 2'd3; x4 = 2'd0; y4 = 2'd3;
         end
         if (i == 4) enter4 = 1'b0;
         if (i < 7) tick();
      end
      tick();
      check("chain_end", zv4, 0);

      // Reset in the middle of a COLSCAN.
      op_4(2'd3, 2'd0, 2'd0);
      tick();
      check("abort_busy_pre", busy4, 1);
      #1 rst = 1'b0;
      #1;
      check("abort_vld", zv4, 0);
      check("abort_busy", busy4, 0);
      check("abort_z", z4, 0);
      @(negedge clk) rst = 1'b1;
      tick();
      check("abort_vld_after", zv4, 0);
      read_4("post_rst00", 2'd0, 2'd0, 1'b0);
      read_4("post_rst11", 2'd1, 2'd1, 1'b0);
      read_4("post_rst13", 2'd1, 2'd3, 1'b0);
      read_4("post_rst33", 2'd3, 2'd3, 1'b0);
`ifdef MATRIXOPS_POPCOUNT_EN
      check("post_rst_pop", pop4, 0);
`endif
      tick();

      // DIM=3: row/column 3 is out of range.
      op_3(2'd0, 2'd3, 2'd0);
      check("d3_toggle_oor_vld", zv3, 0);
`ifdef MATRIXOPS_POPCOUNT_EN
      check("d3_toggle_oor_pop", pop3, 0);
`endif
      op_3(2'd2, 2'd3, 2'd0);
      check("d3_rowscan_oor_busy", busy3, 0);
      check("d3_rowscan_oor_vld", zv3, 0);
      op_3(2'd3, 2'd0, 2'd3);
      check("d3_colscan_oor_busy", busy3, 0);
      check("d3_colscan_oor_vld", zv3, 0);

      op_3(2'd0, 2'd2, 2'd2);
`ifdef MATRIXOPS_POPCOUNT_EN
      check("d3_pop_one", pop3, 1);
`endif
      op_3(2'd1, 2'd2, 2'd2);
      check("d3_read22_vld", zv3, 1);
      check("d3_read22", z3, 1);

      exp3 = 3'b100;
      nbusy = 0;
      op_3(2'd2, 2'd2, 2'd0);
      for (int i = 0; i < 3; i++) begin
         check("d3_row2_vld", zv3, 1);
         check("d3_row2_bit", z3, exp3[i]);
         nbusy += int'(busy3);
         if (i < 2) tick();
      end
      check("d3_row2_busy_cycles", nbusy, 2);
      tick();
      check("d3_row2_end", zv3, 0);

      op_3(2'd0, 2'd2, 2'd2);
`ifdef MATRIXOPS_POPCOUNT_EN
      check("d3_pop_zero", pop3, 0);
`endif
      op_3(2'd1, 2'd2, 2'd2);
      check("d3_read22_again", z3, 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
